hpf_frame_buffer: RTL

HPF_FRAME_BUFFER -- requirements
Module: hpf_frame_buffer

---
 rtl/hpf_frame_buffer_pkg.sv | 16 +
 rtl/hpf_frame_ram.sv | 26 ++
 rtl/hpf_frame_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hpf_frame_buffer_pkg.sv
// Shared constants and types for the HPF frame buffer.
// Sizes, FSM state encoding and the IEEE-754 zero word.
package hpf_frame_buffer_pkg;

  localparam int HPF_DATA_W    = 32;
  localparam int HPF_FRAME_LEN = 80;
  localparam int HPF_WIN_LEN   = 3 * HPF_FRAME_LEN;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_e;

endpackage

// File: rtl/hpf_frame_ram.sv
// WIN_LEN x DATA_W sample store: one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), re/raddr (read), rdata (next cycle).
module hpf_frame_ram
  import hpf_frame_buffer_pkg::*;
#(
  parameter int DATA_W = HPF_DATA_W,
  parameter int DEPTH  = HPF_WIN_LEN,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/hpf_frame_buffer.sv
// Frame/window buffer between the high-pass filter and the analysis stage.
// Captures samples, flags frames, streams the last WIN_LEN samples on request.
module hpf_frame_buffer
  import hpf_frame_buffer_pkg::*;
#(
  parameter int DATA_W    = HPF_DATA_W,
  parameter int FRAME_LEN = HPF_FRAME_LEN,
  parameter int WIN_LEN   = HPF_WIN_LEN
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] hpf_audio_sample,
  input  logic              hpf_smp_valid,
  output logic              frame_rdy,
  input  logic              win_rd_start,
  output logic [DATA_W-1:0] win_sample,
  output logic              win_valid,
  input  logic              win_rd_ready,
  output logic              win_last,
  output logic              ovf_err,
  input  logic              ovf_clr
);

  localparam int AW = $clog2(WIN_LEN);
  localparam int CW = $clog2(WIN_LEN + 1);
  localparam int SW = CW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]     frm_cnt_q, frm_cnt_d;
  logic [CW-1:0]     fill_cnt_q, fill_cnt_d;
  logic [CW-1:0]     snap_fill_q, snap_fill_d;
  logic [CW-1:0]     rd_idx_q, rd_idx_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic              frame_rdy_q, frame_rdy_d;
  logic              frame_pend_q, frame_pend_d;
  logic              ovf_q, ovf_d;
  logic              p_q, p_d, p_zero_q, p_zero_d;
  logic              p_last_q, p_last_d;
  logic              out_v_q, out_v_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              skid_v_q, skid_v_d;
  logic              skid_last_q, skid_last_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  logic              start_acc, xfer, rd_issue, ovf_set;
  logic [1:0]        occ;
  logic [DATA_W-1:0] ram_rdata, land_data;

  hpf_frame_ram #(
    .DATA_W(DATA_W),
    .DEPTH (WIN_LEN),
    .AW    (AW)
  ) u_ram (
    .clk  (sys_clk),
    .we   (hpf_smp_valid),
    .waddr(wr_ptr_q),
    .wdata(hpf_audio_sample),
    .re   (rd_issue),
    .raddr(rd_ptr_q),
    .rdata(ram_rdata)
  );

  // A start is only honoured once the pending flag is visible, so a
  // start coincident with the frame_rdy pulse itself is dropped.
  assign start_acc = (state_q == ST_IDLE) & win_rd_start & frame_pend_q;
  assign xfer      = out_v_q & win_rd_ready;

  // Output reg + skid hold at most two words; a read is only launched
  // when its data is guaranteed a slot on arrival.
  assign occ = {1'b0, out_v_q} + {1'b0, skid_v_q} + {1'b0, p_q};
  assign rd_issue = (state_q == ST_STREAM)
                  & (rd_idx_q != CW'(WIN_LEN))
                  & ((occ - {1'b0, xfer}) < 2'd2);

  assign land_data = p_zero_q ? DATA_W'(FP_ZERO) : ram_rdata;

  // Overtake: the k-th write since the snapshot lands on window index
  // k-1, which is lost if fewer than k samples have been handed out.
  assign ovf_set = hpf_smp_valid & (start_acc
                 | ((state_q == ST_STREAM)
                   & ((SW'(wcnt_q) + SW'(1)) > (SW'(rcnt_q) + SW'(xfer)))));

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    frm_cnt_d   = frm_cnt_q;
    fill_cnt_d  = fill_cnt_q;
    frame_rdy_d = hpf_smp_valid & (frm_cnt_q == FW'(FRAME_LEN - 1));
    if (hpf_smp_valid) begin
      wr_ptr_d  = (wr_ptr_q == AW'(WIN_LEN - 1)) ? '0 : wr_ptr_q + AW'(1);
      frm_cnt_d = (frm_cnt_q == FW'(FRAME_LEN - 1)) ? '0 : frm_cnt_q + FW'(1);
      if (fill_cnt_q != CW'(WIN_LEN)) fill_cnt_d = fill_cnt_q + CW'(1);
    end
    frame_pend_d = (frame_pend_q & ~start_acc) | frame_rdy_q;
    ovf_d        = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    snap_fill_d = snap_fill_q;
    rd_idx_d    = rd_idx_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_acc) begin
          state_d     = ST_STREAM;
          rd_ptr_d    = wr_ptr_q;
          snap_fill_d = fill_cnt_q;
          rd_idx_d    = '0;
          rcnt_d      = '0;
          wcnt_d      = hpf_smp_valid ? CW'(1) : '0;
        end
      end
      ST_STREAM: begin
        if (rd_issue) begin
          rd_idx_d = rd_idx_q + CW'(1);
          rd_ptr_d = (rd_ptr_q == AW'(WIN_LEN - 1)) ? '0
                   : rd_ptr_q + AW'(1);
        end
        if (xfer) rcnt_d = rcnt_q + CW'(1);
        if (hpf_smp_valid && (wcnt_q != CW'(WIN_LEN)))
          wcnt_d = wcnt_q + CW'(1);
        if (xfer && out_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Positions older than the fill level at snapshot time read as zero.
  always_comb begin
    p_d      = rd_issue;
    p_zero_d = (SW'(rd_idx_q) + SW'(snap_fill_q)) < SW'(WIN_LEN);
    p_last_d = (rd_idx_q == CW'(WIN_LEN - 1));
  end

  always_comb begin
    out_v_d     = out_v_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (!out_v_q || xfer) begin
      if (skid_v_q) begin
        out_v_d    = 1'b1;
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        skid_v_d   = p_q;
        if (p_q) begin
          skid_data_d = land_data;
          skid_last_d = p_last_q;
        end
      end else begin
        out_v_d = p_q;
        if (p_q) begin
          out_data_d = land_data;
          out_last_d = p_last_q;
        end
      end
    end else if (p_q) begin
      skid_v_d    = 1'b1;
      skid_data_d = land_data;
      skid_last_d = p_last_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frm_cnt_q    <= '0;
      fill_cnt_q   <= '0;
      snap_fill_q  <= '0;
      rd_idx_q     <= '0;
      wcnt_q       <= '0;
      rcnt_q       <= '0;
      frame_rdy_q  <= 1'b0;
      frame_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
      p_q          <= 1'b0;
      p_zero_q     <= 1'b0;
      p_last_q     <= 1'b0;
      out_v_q      <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      skid_v_q     <= 1'b0;
      skid_last_q  <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frm_cnt_q    <= frm_cnt_d;
      fill_cnt_q   <= fill_cnt_d;
      snap_fill_q  <= snap_fill_d;
      rd_idx_q     <= rd_idx_d;
      wcnt_q       <= wcnt_d;
      rcnt_q       <= rcnt_d;
      frame_rdy_q  <= frame_rdy_d;
      frame_pend_q <= frame_pend_d;
      ovf_q        <= ovf_d;
      p_q          <= p_d;
      p_zero_q     <= p_zero_d;
      p_last_q     <= p_last_d;
      out_v_q      <= out_v_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      skid_v_q     <= skid_v_d;
      skid_last_q  <= skid_last_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign frame_rdy  = frame_rdy_q;
  assign win_valid  = out_v_q;
  assign win_sample = out_data_q;
  assign win_last   = out_last_q;
  assign ovf_err    = ovf_q;

endmodule
